exe_alu_core: RTL and testbench
===============================

// Module: exe_alu_core
// PURPOSE
//  Execute-stage datapath core: two forwarding operand selectors feeding a 32-bit MIPS-style ALU
//  with architectural HI/LO registers. Result is combinational, registered downstream by the
//  EXE/MEM pipeline latch. HI/LO update on the clock edge.
// PARAMETERS
//  none (width fixed at 32; encodings in shared package)
// PORTS
//  CLK        in   1   clock; HI/LO update on posedge
//  RESET      in   1   reset, asynchronous, active-low
//  en         in   1   stage advance; HI/LO write allowed only when 1
//  reg_a      in   5   source register number of operand A
//  opnd_a     in   32  operand A value read from register file/decode
//  reg_b      in   5   source register number of operand B
//  opnd_b     in   32  operand B value (or immediate; set reg_b=0 for immediates)
//  alu_ctrl   in   6   operation select (package encoding)
//  shamt      in   5   shift amount for SLL/SRL/SRA
//  fwd1_reg/fwd1_data/fwd1_valid  in 5/32/1  1st-priority bypass (EXE/MEM latch result)
//  fwd2_reg/fwd2_data/fwd2_valid  in 5/32/1  2nd-priority bypass (MEM/WB result)
//  result     out  32  combinational ALU result
//  a_eff      out  32  operand A after forwarding
//  b_eff      out  32  operand B after forwarding
//  hi, lo     out  32  current HI/LO register contents
// BEHAVIOUR
//  Forwarding per operand: if fwd1_valid && fwd1_reg==reg && reg!=0 -> fwd1_data; else if
//   fwd2_valid && fwd2_reg==reg && reg!=0 -> fwd2_data; else opnd. Both matching -> fwd1 wins.
//  Encodings: 00 NOP(0) 01 ADD 02 SUB 03 AND 04 OR 05 XOR 06 NOR 07 SLT 08 SLTU 09 SLL 0A SRL
//   0B SRA 0C SLLV 0D SRLV 0E SRAV 0F LUI 10 MULT 11 MULTU 12 DIV 13 DIVU 14 MFHI 15 MFLO
//   16 MTHI 17 MTLO; any other code -> result 0, no HI/LO write.
//  ADD/SUB wrap modulo 2^32, no overflow trap. SLT signed, SLTU unsigned; result 1 or 0.
//  SLL/SRL/SRA shift B by shamt; xxxV shift B by A[4:0]; SRA/SRAV sign-fill. LUI = {B[15:0],16'h0}.
//  MFHI/MFLO return registered hi/lo (value before this cycle's edge).
//  MULT/MULTU/DIV/DIVU/MTHI/MTLO: result 0; HI/LO written at posedge CLK when en=1, 1-cycle latency.
//   MULT(U): {HI,LO} = 64-bit signed (unsigned) A*B.
//   DIV(U): LO=quotient (truncate toward zero), HI=remainder (sign of A).
//   Divide by zero: LO=32'hFFFFFFFF, HI=A. DIV 0x80000000/-1: LO=0x80000000, HI=0.
//   MTHI: HI=A, LO unchanged. MTLO: LO=A, HI unchanged.
//  en=0: HI/LO hold; result still computed.
//  Reset: HI=LO=0 immediately on RESET low, regardless of CLK; result/a_eff/b_eff combinational.
// CONFIGURATION
//  EXE_FORWARDING_EN defined: forwarding selectors active as above.
//  Undefined: fwd1_*/fwd2_* ports absent, a_eff=opnd_a, b_eff=opnd_b; all else identical.
// STRUCTURE
//  Package exe_alu_pkg: alu_ctrl localparams (codes above), 32-bit word typedef.
//  Sub-module exe_operand_fwd (one 5-bit reg + value, two prioritized bypasses -> value),
//   instantiated twice (A, B); omitted when EXE_FORWARDING_EN undefined.
// TESTING
//  ADD A=0x7FFFFFFF B=1 -> result 0x80000000; SLT A=-1 B=1 -> 1; SLTU same operands -> 0.
//  SRA B=0x80000000 shamt=4 -> 0xF8000000; SRLV A=36 B=0xF0 -> 0x0F (A[4:0]=4).
//  MULT A=-2 B=3, en=1, edge -> HI=0xFFFFFFFF LO=0xFFFFFFFA; MFLO next cycle -> 0xFFFFFFFA;
//   repeat with en=0 -> HI/LO unchanged.
//  DIV A=-7 B=2 -> LO=-3 HI=-1; DIVU A=5 B=0 -> LO=0xFFFFFFFF HI=5.
//  Forwarding: reg_a=5, fwd1 {5,0xAA,1}, fwd2 {5,0xBB,1} -> a_eff=0xAA; fwd1_valid=0 -> 0xBB;
//   reg_a=0 with both matching -> opnd_a.
//  RESET low mid-run after MTHI 0x1234 -> hi=0 asynchronously, held until RESET high.

Source files
------------

// File: rtl/exe_alu_pkg.sv
// exe_alu_pkg: shared ALU operation encodings and the 32-bit datapath word type
// Contents: word_t (32-bit word), ALU_* alu_ctrl codes (6 bits). No ports.
package exe_alu_pkg;
   typedef logic [31:0] word_t;
   localparam logic [5:0] ALU_NOP   = 6'h00;
   localparam logic [5:0] ALU_ADD   = 6'h01;
   localparam logic [5:0] ALU_SUB   = 6'h02;
   localparam logic [5:0] ALU_AND   = 6'h03;
   localparam logic [5:0] ALU_OR    = 6'h04;
   localparam logic [5:0] ALU_XOR   = 6'h05;
   localparam logic [5:0] ALU_NOR   = 6'h06;
   localparam logic [5:0] ALU_SLT   = 6'h07;
   localparam logic [5:0] ALU_SLTU  = 6'h08;
   localparam logic [5:0] ALU_SLL   = 6'h09;
   localparam logic [5:0] ALU_SRL   = 6'h0A;
   localparam logic [5:0] ALU_SRA   = 6'h0B;
   localparam logic [5:0] ALU_SLLV  = 6'h0C;
   localparam logic [5:0] ALU_SRLV  = 6'h0D;
   localparam logic [5:0] ALU_SRAV  = 6'h0E;
   localparam logic [5:0] ALU_LUI   = 6'h0F;
   localparam logic [5:0] ALU_MULT  = 6'h10;
   localparam logic [5:0] ALU_MULTU = 6'h11;
   localparam logic [5:0] ALU_DIV   = 6'h12;
   localparam logic [5:0] ALU_DIVU  = 6'h13;
   localparam logic [5:0] ALU_MFHI  = 6'h14;
   localparam logic [5:0] ALU_MFLO  = 6'h15;
   localparam logic [5:0] ALU_MTHI  = 6'h16;
   localparam logic [5:0] ALU_MTLO  = 6'h17;
endpackage

// File: rtl/exe_operand_fwd.sv
// exe_operand_fwd: selects one operand value from two prioritized bypasses or the read value
// Ports: i_reg (5) source register, i_opnd (32) read value,
//        i_fwd1_reg/i_fwd1_data/i_fwd1_valid first-priority bypass,
//        i_fwd2_reg/i_fwd2_data/i_fwd2_valid second-priority bypass,
//        o_value (32) selected operand. Register 0 never forwards.
module exe_operand_fwd
   import exe_alu_pkg::*;
(
   input  logic [4:0] i_reg,
   input  word_t      i_opnd,
   input  logic [4:0] i_fwd1_reg,
   input  word_t      i_fwd1_data,
   input  logic       i_fwd1_valid,
   input  logic [4:0] i_fwd2_reg,
   input  word_t      i_fwd2_data,
   input  logic       i_fwd2_valid,
   output word_t      o_value
);
   logic w_hit1, w_hit2;
   assign w_hit1  = i_fwd1_valid && (i_fwd1_reg == i_reg) && (i_reg != 5'd0);
   assign w_hit2  = i_fwd2_valid && (i_fwd2_reg == i_reg) && (i_reg != 5'd0);
   assign o_value = w_hit1 ? i_fwd1_data : w_hit2 ? i_fwd2_data : i_opnd;
endmodule

// File: rtl/exe_alu_core.sv
// exe_alu_core: execute-stage operand forwarding plus 32-bit MIPS-style ALU with HI/LO registers
// Ports: CLK, RESET (async, active-low), en (HI/LO write enable), reg_a/opnd_a, reg_b/opnd_b,
//        alu_ctrl (6), shamt (5), fwd1_*/fwd2_* bypasses (only with EXE_FORWARDING_EN),
//        result (combinational), a_eff/b_eff (forwarded operands), hi/lo (registered).
// Build option: EXE_FORWARDING_EN enables the bypass ports and selectors; otherwise the
//        operands pass straight through.
module exe_alu_core
   import exe_alu_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       en,
   input  logic [4:0] reg_a,
   input  word_t      opnd_a,
   input  logic [4:0] reg_b,
   input  word_t      opnd_b,
   input  logic [5:0] alu_ctrl,
   input  logic [4:0] shamt,
`ifdef EXE_FORWARDING_EN
   input  logic [4:0] fwd1_reg,
   input  word_t      fwd1_data,
   input  logic       fwd1_valid,
   input  logic [4:0] fwd2_reg,
   input  word_t      fwd2_data,
   input  logic       fwd2_valid,
`endif
   output word_t      result,
   output word_t      a_eff,
   output word_t      b_eff,
   output word_t      hi,
   output word_t      lo
);
   word_t       r_hi, r_lo;
   word_t       w_hi_nxt, w_lo_nxt;
   logic [63:0] w_prod_s, w_prod_u;
   word_t       w_ua, w_ub, w_div_b, w_uq, w_ur, w_sq, w_sr, w_q, w_r;
   logic        w_div_signed;

`ifdef EXE_FORWARDING_EN
   exe_operand_fwd u_fwd_a (
      .i_reg(reg_a), .i_opnd(opnd_a),
      .i_fwd1_reg(fwd1_reg), .i_fwd1_data(fwd1_data), .i_fwd1_valid(fwd1_valid),
      .i_fwd2_reg(fwd2_reg), .i_fwd2_data(fwd2_data), .i_fwd2_valid(fwd2_valid),
      .o_value(a_eff)
   );
   exe_operand_fwd u_fwd_b (
      .i_reg(reg_b), .i_opnd(opnd_b),
      .i_fwd1_reg(fwd1_reg), .i_fwd1_data(fwd1_data), .i_fwd1_valid(fwd1_valid),
      .i_fwd2_reg(fwd2_reg), .i_fwd2_data(fwd2_data), .i_fwd2_valid(fwd2_valid),
      .o_value(b_eff)
   );
`else
   logic [9:0] w_unused_regs;
   assign w_unused_regs = {reg_a, reg_b};
   assign a_eff = opnd_a;
   assign b_eff = opnd_b;
`endif

   // Products formed on explicitly extended 64-bit operands so the low 64 bits are exact.
   assign w_prod_s = {{32{a_eff[31]}}, a_eff} * {{32{b_eff[31]}}, b_eff};
   assign w_prod_u = {32'd0, a_eff} * {32'd0, b_eff};

   // Signed divide via magnitudes: avoids relying on native signed-division overflow
   // behaviour, and naturally yields 0x80000000 rem 0 for 0x80000000 / -1.
   assign w_div_signed = (alu_ctrl == ALU_DIV);
   assign w_ua    = (w_div_signed && a_eff[31]) ? -a_eff : a_eff;
   assign w_ub    = (w_div_signed && b_eff[31]) ? -b_eff : b_eff;
   assign w_div_b = (w_ub == 32'd0) ? 32'd1 : w_ub;
   assign w_uq    = w_ua / w_div_b;
   assign w_ur    = w_ua % w_div_b;
   assign w_sq    = (w_div_signed && (a_eff[31] ^ b_eff[31])) ? -w_uq : w_uq;
   assign w_sr    = (w_div_signed && a_eff[31]) ? -w_ur : w_ur;
   assign w_q     = (b_eff == 32'd0) ? 32'hFFFF_FFFF : w_sq;
   assign w_r     = (b_eff == 32'd0) ? a_eff : w_sr;

   always_comb begin
      result = 32'd0;
      case (alu_ctrl)
         ALU_ADD:  result = a_eff + b_eff;
         ALU_SUB:  result = a_eff - b_eff;
         ALU_AND:  result = a_eff & b_eff;
         ALU_OR:   result = a_eff | b_eff;
         ALU_XOR:  result = a_eff ^ b_eff;
         ALU_NOR:  result = ~(a_eff | b_eff);
         ALU_SLT:  result = {31'd0, $signed(a_eff) < $signed(b_eff)};
         ALU_SLTU: result = {31'd0, a_eff < b_eff};
         ALU_SLL:  result = b_eff << shamt;
         ALU_SRL:  result = b_eff >> shamt;
         ALU_SRA:  result = $unsigned($signed(b_eff) >>> shamt);
         ALU_SLLV: result = b_eff << a_eff[4:0];
         ALU_SRLV: result = b_eff >> a_eff[4:0];
         ALU_SRAV: result = $unsigned($signed(b_eff) >>> a_eff[4:0]);
         ALU_LUI:  result = {b_eff[15:0], 16'h0000};
         ALU_MFHI: result = r_hi;
         ALU_MFLO: result = r_lo;
         default:  result = 32'd0;
      endcase
   end

   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      case (alu_ctrl)
         ALU_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
         ALU_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
         ALU_DIV,
         ALU_DIVU:  {w_hi_nxt, w_lo_nxt} = {w_r, w_q};
         ALU_MTHI:  w_hi_nxt = a_eff;
         ALU_MTLO:  w_lo_nxt = a_eff;
         default:   ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (en) begin
         r_hi <= w_hi_nxt;
         r_lo <= w_lo_nxt;
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;
endmodule

// File: tb/tb_exe_alu_core.sv
// tb_exe_alu_core: directed-vector scoreboard bench for exe_alu_core
module tb_exe_alu_core;
   import exe_alu_pkg::*;

   localparam int K_RES = 0, K_HI = 1, K_LO = 2, K_A = 3, K_B = 4;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] val;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        en = 1'b0;
   logic [4:0]  reg_a = '0, reg_b = '0, shamt = '0;
   logic [31:0] opnd_a = '0, opnd_b = '0;
   logic [5:0]  alu_ctrl = ALU_NOP;
   logic [31:0] result, a_eff, b_eff, hi, lo;
`ifdef EXE_FORWARDING_EN
   logic [4:0]  fwd1_reg = '0, fwd2_reg = '0;
   logic [31:0] fwd1_data = '0, fwd2_data = '0;
   logic        fwd1_valid = 1'b0, fwd2_valid = 1'b0;
`endif

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   exe_alu_core dut (
      .CLK(CLK), .RESET(RESET), .en(en),
      .reg_a(reg_a), .opnd_a(opnd_a), .reg_b(reg_b), .opnd_b(opnd_b),
      .alu_ctrl(alu_ctrl), .shamt(shamt),
`ifdef EXE_FORWARDING_EN
      .fwd1_reg(fwd1_reg), .fwd1_data(fwd1_data), .fwd1_valid(fwd1_valid),
      .fwd2_reg(fwd2_reg), .fwd2_data(fwd2_data), .fwd2_valid(fwd2_valid),
`endif
      .result(result), .a_eff(a_eff), .b_eff(b_eff), .hi(hi), .lo(lo)
   );

   function automatic void expect_val(string n, int k, logic [31:0] v);
      exp_t e;
      e.name = n;
      e.kind = k;
      e.val  = v;
      q.push_back(e);
   endfunction

   // Monitor: outputs are stable at the falling edge; drain every expectation queued this cycle.
   always @(negedge CLK) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = (e.kind == K_RES) ? result : (e.kind == K_HI) ? hi :
               (e.kind == K_LO) ? lo : (e.kind == K_A) ? a_eff : b_eff;
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic op(logic [5:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] s, logic e);
      alu_ctrl = c;
      opnd_a   = a;
      opnd_b   = b;
      shamt    = s;
      en       = e;
   endtask

   // One combinational result vector per cycle.
   task automatic rv(string n, logic [5:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] s,
                     logic [31:0] exp_r);
      cyc();
      op(c, a, b, s, 1'b0);
      expect_val(n, K_RES, exp_r);
   endtask

   // Issue a HI/LO-writing op, then check the registers one cycle later.
   task automatic hl(string n, logic [5:0] c, logic [31:0] a, logic [31:0] b, logic e,
                     logic [31:0] exp_hi, logic [31:0] exp_lo);
      cyc();
      op(c, a, b, 5'd0, e);
      expect_val({n, "_res"}, K_RES, 32'd0);
      cyc();
      op(ALU_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      expect_val({n, "_hi"}, K_HI, exp_hi);
      expect_val({n, "_lo"}, K_LO, exp_lo);
   endtask

   initial begin
      cyc();
      op(ALU_MTHI, 32'h5555, 32'd0, 5'd0, 1'b1);
      expect_val("reset_hi", K_HI, 32'd0);
      expect_val("reset_lo", K_LO, 32'd0);
      cyc();
      RESET = 1'b1;
      op(ALU_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

      rv("add_wrap", ALU_ADD,  32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000);
      rv("sub",      ALU_SUB,  32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE);
      rv("and",      ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000);
      rv("or",       ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0);
      rv("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0);
      rv("nor",      ALU_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h000F_000F);
      rv("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1);
      rv("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0);
      rv("sll",      ALU_SLL,  32'd0,         32'd1,         5'd31, 32'h8000_0000);
      rv("srl",      ALU_SRL,  32'd0,         32'h8000_0000, 5'd4,  32'h0800_0000);
      rv("sra",      ALU_SRA,  32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000);
      rv("sllv",     ALU_SLLV, 32'd33,        32'd3,         5'd0,  32'd6);
      rv("srlv",     ALU_SRLV, 32'd36,        32'hF0,        5'd0,  32'h0F);
      rv("srav",     ALU_SRAV, 32'd8,         32'h8000_0000, 5'd0,  32'hFF80_0000);
      rv("lui",      ALU_LUI,  32'd0,         32'h0001_ABCD, 5'd0,  32'hABCD_0000);
      rv("nop",      ALU_NOP,  32'd1,         32'd1,         5'd0,  32'd0);
      rv("bad_code", 6'h3F,    32'd1,         32'd1,         5'd0,  32'd0);
      expect_val("a_pass", K_A, 32'd1);

      hl("mult",  ALU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      expect_val("mflo_res", K_RES, 32'd0);
      rv("mflo", ALU_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFA);
      rv("mfhi", ALU_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
      hl("mult_en0", ALU_MULT, 32'd2, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      hl("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE);
      hl("div",   ALU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      hl("div_nd", ALU_DIV,  32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD);
      hl("divu0", ALU_DIVU,  32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF);
      hl("div0s", ALU_DIV,   32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      hl("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
      hl("divu",  ALU_DIVU,  32'hFFFF_FFF9, 32'd2, 1'b1, 32'd1, 32'h7FFF_FFFC);
      hl("mthi",  ALU_MTHI,  32'h1234, 32'd0, 1'b1, 32'h1234, 32'h7FFF_FFFC);
      hl("mtlo",  ALU_MTLO,  32'h55, 32'd0, 1'b1, 32'h1234, 32'h55);
      hl("bad_wr", 6'h20,    32'h9, 32'h9, 1'b1, 32'h1234, 32'h55);

      // Reset asserted between edges: the falling-edge sample precedes any rising edge.
      cyc();
      RESET = 1'b0;
      op(ALU_MTHI, 32'h999, 32'd0, 5'd0, 1'b1);
      expect_val("async_rst_hi", K_HI, 32'd0);
      expect_val("async_rst_lo", K_LO, 32'd0);
      cyc();
      expect_val("rst_hold_hi", K_HI, 32'd0);
      cyc();
      RESET = 1'b1;
      op(ALU_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      cyc();
      expect_val("post_rst_hi", K_HI, 32'd0);

`ifdef EXE_FORWARDING_EN
      cyc();
      op(ALU_ADD, 32'h11, 32'h22, 5'd0, 1'b0);
      reg_a = 5'd5; reg_b = 5'd7;
      fwd1_reg = 5'd5; fwd1_data = 32'hAA; fwd1_valid = 1'b1;
      fwd2_reg = 5'd5; fwd2_data = 32'hBB; fwd2_valid = 1'b1;
      expect_val("fwd1_wins", K_A, 32'hAA);
      expect_val("fwd_b_none", K_B, 32'h22);
      expect_val("fwd_add", K_RES, 32'hCC);
      cyc();
      fwd1_valid = 1'b0;
      expect_val("fwd2_sel", K_A, 32'hBB);
      cyc();
      fwd1_valid = 1'b1;
      reg_a = 5'd0; fwd1_reg = 5'd0; fwd2_reg = 5'd0;
      expect_val("fwd_r0", K_A, 32'h11);
      cyc();
      reg_b = 5'd7; fwd1_reg = 5'd3; fwd2_reg = 5'd7;
      expect_val("fwd2_b", K_B, 32'hBB);
      cyc();
      fwd1_valid = 1'b0; fwd2_valid = 1'b0;
`else
      cyc();
      op(ALU_ADD, 32'h11, 32'h22, 5'd0, 1'b0);
      reg_a = 5'd5; reg_b = 5'd7;
      expect_val("pass_a", K_A, 32'h11);
      expect_val("pass_b", K_B, 32'h22);
      expect_val("pass_add", K_RES, 32'h33);
`endif

      cyc();
      @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
